// File: rtl/prbs_run_ctrl.sv
// ----------------------------------------------------------------------------
// prbs_run_ctrl
//   Sequences one PRBS test run: holds the generator in reset for ARM_CYCLES,
//   lets it free-run for cfg_run_len byte cycles with the detector enabled,
//   then optionally waits up to cfg_timeout cycles for a late detector hit.
//   The result is reported with a one-cycle done pulse and a pass flag.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   start                    run request (accepted only in IDLE, abort low)
//   abort                    cancel the run from any busy state
//   cfg_pattern/cfg_repeats  generator seed, latched on an accepted start
//   cfg_run_len              run length in generator bytes (cycles)
//   cfg_timeout              post-run detection window in cycles
//   det_found                detector hit, one cycle per hit
//   gen_rst_n                active-low generator reset
//   gen_pattern/gen_repeats  latched generator seed
//   det_en                   detector enable
//   busy                     high in every state except IDLE
//   done                     one-cycle run-complete pulse
//   pass                     run result, valid from done until next start
//   byte_cnt                 bytes elapsed in the current or last run
// ----------------------------------------------------------------------------
module prbs_run_ctrl #(
    parameter int unsigned ARM_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] cfg_pattern,
    input  logic [7:0]  cfg_repeats,
    input  logic [15:0] cfg_run_len,
    input  logic [7:0]  cfg_timeout,
    input  logic        det_found,
    output logic        gen_rst_n,
    output logic [31:0] gen_pattern,
    output logic [7:0]  gen_repeats,
    output logic        det_en,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] byte_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [3:0] ARM_LAST = 4'(ARM_CYCLES - 1);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [3:0]  arm_cnt;
    logic [7:0]  tmo_cnt;
    logic [15:0] run_len_q;
    logic [7:0]  timeout_q;
    logic [15:0] byte_cnt_inc;
    logic        accept;
    logic        run_last;

    assign accept       = (state == S_IDLE) && start && !abort;
    assign byte_cnt_inc = byte_cnt + 16'd1;
    // Last RUN cycle: the increment on this edge reaches the run length.
    assign run_last     = (byte_cnt_inc == run_len_q);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (cfg_run_len == 16'd0) ? S_DONE : S_ARM;
                end
            end
            S_ARM: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (arm_cnt == ARM_LAST) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (run_last) begin
                    // A hit on the final byte cycle still counts.
                    state_nxt = (pass || det_found) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (det_found || (tmo_cnt == timeout_q)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are true flops that
    // line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            arm_cnt     <= '0;
            tmo_cnt     <= '0;
            run_len_q   <= '0;
            timeout_q   <= '0;
            gen_rst_n   <= 1'b0;
            gen_pattern <= '0;
            gen_repeats <= '0;
            det_en      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            byte_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            gen_rst_n <= (state_nxt == S_RUN) || (state_nxt == S_WAIT);
            det_en    <= (state_nxt == S_RUN) || (state_nxt == S_WAIT);
            busy      <= (state_nxt != S_IDLE);
            done      <= (state_nxt == S_DONE);

            arm_cnt <= ((state == S_ARM) && (state_nxt == S_ARM)) ? arm_cnt + 4'd1 : '0;
            tmo_cnt <= ((state == S_WAIT) && (state_nxt == S_WAIT)) ? tmo_cnt + 8'd1 : '0;

            if (accept) begin
                gen_pattern <= cfg_pattern;
                gen_repeats <= cfg_repeats;
                run_len_q   <= cfg_run_len;
                timeout_q   <= cfg_timeout;
                byte_cnt    <= '0;
                pass        <= 1'b0;
            end else begin
                if ((state == S_RUN) && !abort) begin
                    byte_cnt <= byte_cnt_inc;
                end
                if (abort && (state != S_IDLE)) begin
                    pass <= 1'b0;
                end else if (((state == S_RUN) || (state == S_WAIT)) && det_found) begin
                    pass <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prbs_run_ctrl.sv
// ----------------------------------------------------------------------------
// tb_prbs_run_ctrl
//   Directed bench for prbs_run_ctrl. Cycle 1 is the cycle after the edge that
//   samples start; expected cycle numbers and counts are worked out by hand
//   from the run timing (ARM = 2 cycles, RUN = run length cycles, WAIT up to
//   timeout+1 cycles, then one DONE cycle).
// ----------------------------------------------------------------------------
module tb_prbs_run_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] cfg_pattern;
    logic [7:0]  cfg_repeats;
    logic [15:0] cfg_run_len;
    logic [7:0]  cfg_timeout;
    logic        det_found;
    logic        gen_rst_n;
    logic [31:0] gen_pattern;
    logic [7:0]  gen_repeats;
    logic        det_en;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] byte_cnt;

    int n_cmp = 0;
    int n_err = 0;

    prbs_run_ctrl #(.ARM_CYCLES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .cfg_pattern (cfg_pattern),
        .cfg_repeats (cfg_repeats),
        .cfg_run_len (cfg_run_len),
        .cfg_timeout (cfg_timeout),
        .det_found   (det_found),
        .gen_rst_n   (gen_rst_n),
        .gen_pattern (gen_pattern),
        .gen_repeats (gen_repeats),
        .det_en      (det_en),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .byte_cnt    (byte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one run and observe it for ncyc cycles. det_c / abort_c give the
    // cycle on which det_found / abort are held high (0 = never). While busy
    // on cycle 2 the cfg inputs are scrambled and start re-pulsed; the run in
    // progress must ignore both.
    task automatic do_run(input logic [31:0] pat, input logic [7:0] rep,
                          input logic [15:0] len, input logic [7:0] tmo,
                          input int det_c, input int abort_c, input int ncyc,
                          output int done_c, output int done_n,
                          output int hi_n, output int first_hi, output int den_n);
        cfg_pattern = pat;
        cfg_repeats = rep;
        cfg_run_len = len;
        cfg_timeout = tmo;
        start = 1'b1;
        tick();
        start = 1'b0;
        done_c = 0; done_n = 0; hi_n = 0; first_hi = 0; den_n = 0;
        for (int c = 1; c <= ncyc; c++) begin
            if (done) begin
                done_n++;
                if (done_c == 0) done_c = c;
            end
            if (gen_rst_n) begin
                hi_n++;
                if (first_hi == 0) first_hi = c;
            end
            if (det_en) den_n++;
            det_found = (c == det_c);
            abort     = (c == abort_c);
            start     = (c == 2) && busy;
            if (c == 2) begin
                cfg_pattern = ~pat;
                cfg_repeats = ~rep;
                cfg_run_len = ~len;
                cfg_timeout = ~tmo;
            end
            tick();
        end
        det_found = 1'b0;
        abort     = 1'b0;
        start     = 1'b0;
    endtask

    int done_c, done_n, hi_n, first_hi, den_n;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; det_found = 1'b0;
        cfg_pattern = '0; cfg_repeats = '0; cfg_run_len = '0; cfg_timeout = '0;
        tick(); tick();
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_gen_rst_n", 32'(gen_rst_n), 32'd0);
        check("rst_pattern",   gen_pattern, 32'd0);
        check("rst_byte_cnt",  32'(byte_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Normal run: length 16, hit on RUN cycle 5 (bench cycle 7).
        do_run(32'hA5A5_1234, 8'h3C, 16'd16, 8'd8, 7, 0, 24, done_c, done_n, hi_n, first_hi, den_n);
        check("t1_first_hi", first_hi, 3);
        check("t1_hi_cnt",   hi_n, 16);
        check("t1_det_en",   den_n, 16);
        check("t1_done_cyc", done_c, 19);
        check("t1_done_cnt", done_n, 1);
        check("t1_pass",     32'(pass), 32'd1);
        check("t1_byte_cnt", 32'(byte_cnt), 32'd16);
        check("t1_pattern",  gen_pattern, 32'hA5A5_1234);
        check("t1_repeats",  32'(gen_repeats), 32'h3C);
        check("t1_busy_end", 32'(busy), 32'd0);

        // Zero length: straight to DONE, pass and byte_cnt cleared.
        do_run(32'h0000_0F0F, 8'h11, 16'd0, 8'd5, 0, 0, 4, done_c, done_n, hi_n, first_hi, den_n);
        check("t4_done_cyc", done_c, 1);
        check("t4_done_cnt", done_n, 1);
        check("t4_hi_cnt",   hi_n, 0);
        check("t4_pass",     32'(pass), 32'd0);
        check("t4_byte_cnt", 32'(byte_cnt), 32'd0);
        check("t4_pattern",  gen_pattern, 32'h0000_0F0F);

        // Late hit: length 4, WAIT starts at cycle 7, hit on WAIT cycle 3.
        do_run(32'h1111_2222, 8'h22, 16'd4, 8'd10, 9, 0, 14, done_c, done_n, hi_n, first_hi, den_n);
        check("t2_done_cyc", done_c, 10);
        check("t2_hi_cnt",   hi_n, 7);
        check("t2_pass",     32'(pass), 32'd1);
        check("t2_byte_cnt", 32'(byte_cnt), 32'd4);

        // Timeout: length 4, timeout 3 -> WAIT on cycles 7..10, done at 11.
        do_run(32'h3333_4444, 8'h33, 16'd4, 8'd3, 0, 0, 15, done_c, done_n, hi_n, first_hi, den_n);
        check("t3_done_cyc", done_c, 11);
        check("t3_done_cnt", done_n, 1);
        check("t3_hi_cnt",   hi_n, 8);
        check("t3_pass",     32'(pass), 32'd0);
        check("t3_byte_cnt", 32'(byte_cnt), 32'd4);

        // Abort in RUN while byte_cnt shows 7 (cycle 10); earlier hit is discarded.
        do_run(32'h5555_6666, 8'h44, 16'd16, 8'd8, 5, 10, 14, done_c, done_n, hi_n, first_hi, den_n);
        check("t5_done_cnt", done_n, 0);
        check("t5_hi_cnt",   hi_n, 8);
        check("t5_pass",     32'(pass), 32'd0);
        check("t5_byte_cnt", 32'(byte_cnt), 32'd7);
        check("t5_gen_rst",  32'(gen_rst_n), 32'd0);

        // start together with abort in IDLE is ignored.
        cfg_pattern = 32'hDEAD_BEEF; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        check("sa_busy",     32'(busy), 32'd0);
        check("sa_pattern",  gen_pattern, 32'h5555_6666);
        check("sa_byte_cnt", 32'(byte_cnt), 32'd7);

        // Async reset mid-WAIT after a start issued while busy.
        cfg_pattern = 32'h1357_9BDF; cfg_repeats = 8'h55;
        cfg_run_len = 16'd4; cfg_timeout = 8'd20; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        cfg_pattern = 32'hFFFF_0000; start = 1'b1;
        tick();
        start = 1'b0;
        check("r_busy_start_pat", gen_pattern, 32'h1357_9BDF);
        repeat (4) tick();
        check("r_wait_busy",   32'(busy), 32'd1);
        check("r_wait_gen_rst", 32'(gen_rst_n), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("r_async_busy",    32'(busy), 32'd0);
        check("r_async_gen_rst", 32'(gen_rst_n), 32'd0);
        check("r_async_det_en",  32'(det_en), 32'd0);
        check("r_async_pattern", gen_pattern, 32'd0);
        check("r_async_repeats", 32'(gen_repeats), 32'd0);
        check("r_async_byte",    32'(byte_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Hit on the final RUN cycle goes straight to DONE.
        do_run(32'h2468_ACE0, 8'h66, 16'd3, 8'd0, 5, 0, 9, done_c, done_n, hi_n, first_hi, den_n);
        check("t6_done_cyc", done_c, 6);
        check("t6_hi_cnt",   hi_n, 3);
        check("t6_pass",     32'(pass), 32'd1);
        check("t6_byte_cnt", 32'(byte_cnt), 32'd3);

        // Timeout 0, no hit: one WAIT cycle (5), done at 6.
        do_run(32'h0BAD_F00D, 8'h77, 16'd2, 8'd0, 0, 0, 9, done_c, done_n, hi_n, first_hi, den_n);
        check("t7_done_cyc", done_c, 6);
        check("t7_hi_cnt",   hi_n, 3);
        check("t7_pass",     32'(pass), 32'd0);

        // Timeout 0 with a hit on that single WAIT cycle.
        do_run(32'h0BAD_F00E, 8'h78, 16'd2, 8'd0, 5, 0, 9, done_c, done_n, hi_n, first_hi, den_n);
        check("t8_done_cyc", done_c, 6);
        check("t8_pass",     32'(pass), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
